// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: PS/2 keyboard receiver that filters the pin clock, deserialises
// 11-bit frames (start/8 data/odd parity/stop), folds E0/F0 prefixes into one key
// event {ext, brk, code} and queues events in a show-ahead FIFO.
// Ports: clk/rst system clock and async active-high reset; ps2_clk/ps2_data raw pins;
//   ev_valid/ev_code/ev_break/ev_ext head of queue, popped by ev_ack; fifo_count
//   occupancy; overflow (sticky) and err_cnt (saturating), both cleared by clr_status.
module ps2_event_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int KEEP_BREAK  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          ev_ack,
    input  logic                          clr_status,
    output logic                          ev_valid,
    output logic [7:0]                    ev_code,
    output logic                          ev_break,
    output logic                          ev_ext,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [7:0]                    err_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers; both lines idle high so they reset to 1.
    // ------------------------------------------------------------------
    logic [1:0] clk_sync;
    logic [1:0] dat_sync;
    logic       s_clk;
    logic       s_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    assign s_clk = clk_sync[1];
    assign s_dat = dat_sync[1];

    // ------------------------------------------------------------------
    // Clock glitch filter: the filtered clock follows s_clk only after
    // s_clk has disagreed with it for FILTER_LEN consecutive cycles.
    // ------------------------------------------------------------------
    logic [FW-1:0] flt_cnt;
    logic          filt_clk;
    logic          filt_clk_d;
    logic          fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_cnt    <= '0;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            filt_clk_d <= filt_clk;
            if (s_clk != filt_clk) begin
                if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt_clk <= s_clk;
                    flt_cnt  <= '0;
                end else begin
                    flt_cnt <= flt_cnt + 1'b1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    // High for exactly the first cycle in which the filtered clock is 0.
    assign fall = filt_clk_d & ~filt_clk;

    // ------------------------------------------------------------------
    // Frame receiver
    // ------------------------------------------------------------------
    rx_state_t     state;
    rx_state_t     state_nxt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          frame_good;
    logic          frame_err;
    logic          timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_good = 1'b0;
        frame_err  = 1'b0;
        timeout    = 1'b0;
        if (fall) begin
            case (state)
                ST_IDLE:   if (!s_dat) state_nxt = ST_DATA;
                ST_DATA:   if (bit_idx == 3'd7) state_nxt = ST_PARITY;
                ST_PARITY: state_nxt = ST_STOP;
                ST_STOP: begin
                    state_nxt = ST_IDLE;
                    // Odd parity over data+parity, and a high stop bit.
                    if (s_dat && (^{par_bit, shreg})) begin
                        frame_good = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default:   state_nxt = ST_IDLE;
            endcase
        end else if ((state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYC))) begin
            timeout   = 1'b1;
            state_nxt = ST_IDLE;
        end
    end

    logic       byte_vld;
    logic [7:0] byte_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            to_cnt   <= '0;
            byte_vld <= 1'b0;
            byte_q   <= '0;
        end else begin
            if (fall && (state == ST_IDLE)) begin
                bit_idx <= '0;
            end
            if (fall && (state == ST_DATA)) begin
                shreg   <= {s_dat, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (fall && (state == ST_PARITY)) begin
                par_bit <= s_dat;
            end
            // Inter-edge watchdog; saturates so the abort condition holds
            // until the FSM leaves the frame.
            if ((state == ST_IDLE) || fall) begin
                to_cnt <= '0;
            end else if (to_cnt != TW'(TIMEOUT_CYC)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            byte_vld <= frame_good;
            if (frame_good) begin
                byte_q <= shreg;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix folding: E0/F0 only set flags, 00/FF are keyboard error
    // codes and are swallowed, anything else becomes an event.
    // ------------------------------------------------------------------
    logic       ext_q;
    logic       brk_q;
    logic       ev_push;
    logic [9:0] ev_dat;

    always_comb begin
        ev_push = 1'b0;
        ev_dat  = {ext_q, brk_q, byte_q};
        if (byte_vld) begin
            case (byte_q)
                8'hE0, 8'hF0, 8'h00, 8'hFF: ev_push = 1'b0;
                default: ev_push = (KEEP_BREAK != 0) || !brk_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (byte_vld) begin
            case (byte_q)
                8'hE0:   ext_q <= 1'b1;
                8'hF0:   brk_q <= 1'b1;
                default: begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead event FIFO
    // ------------------------------------------------------------------
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          ovf_set;
    logic [9:0]    head;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign ev_valid = (count != '0);
    assign pop     = ev_ack & ev_valid;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign wr_en   = ev_push & (~full | pop);
    assign ovf_set = ev_push & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= ev_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign ev_code    = head[7:0];
    assign ev_break   = head[8];
    assign ev_ext     = head[9];
    assign fifo_count = count;

    // ------------------------------------------------------------------
    // Status: an error in the same cycle as clr_status survives the clear.
    // ------------------------------------------------------------------
    logic err_inc;
    assign err_inc = frame_err | timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (clr_status) begin
                err_cnt <= err_inc ? 8'd1 : 8'd0;
            end else if (err_inc && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_status) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_event_fifo.sv
module tb_ps2_event_fifo;

    localparam int DEPTH = 8;
    localparam int HALF  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ev_ack = 1'b0;
    logic       clr_status = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_break;
    logic       ev_ext;
    logic [3:0] fifo_count;
    logic       overflow;
    logic [7:0] err_cnt;

    logic       nb_ack = 1'b0;
    logic       nb_clr = 1'b0;
    logic       nb_valid;
    logic [7:0] nb_code;
    logic       nb_break;
    logic       nb_ext;
    logic [3:0] nb_count;
    logic       nb_overflow;
    logic [7:0] nb_err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ps2_event_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYC(100), .KEEP_BREAK(1)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ev_ack(ev_ack), .clr_status(clr_status),
        .ev_valid(ev_valid), .ev_code(ev_code), .ev_break(ev_break), .ev_ext(ev_ext),
        .fifo_count(fifo_count), .overflow(overflow), .err_cnt(err_cnt)
    );

    ps2_event_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYC(100), .KEEP_BREAK(0)) dut_nb (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ev_ack(nb_ack), .clr_status(nb_clr),
        .ev_valid(nb_valid), .ev_code(nb_code), .ev_break(nb_break), .ev_ext(nb_ext),
        .fifo_count(nb_count), .overflow(nb_overflow), .err_cnt(nb_err_cnt)
    );

    // ---------------- stimulus helpers ----------------
    task automatic apply_reset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ev_ack   = 1'b0;
        clr_status = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        @(posedge clk);
        #1 ps2_data = b;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    // Sends start..parity, then drops the clock for the stop bit and returns
    // 7 clk edges later: the next clk edge is the one that writes the FIFO.
    task automatic frame_head(input logic [7:0] code, input logic flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit((~^code) ^ flip);
        @(posedge clk);
        #1 ps2_data = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (7) @(posedge clk);
    endtask

    task automatic frame_tail();
        repeat (3) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic flip);
        frame_head(code, flip);
        frame_tail();
    endtask

    task automatic pop_dut();
        @(posedge clk);
        #1 ev_ack = 1'b1;
        @(posedge clk);
        #1 ev_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_status = 1'b1;
        @(posedge clk);
        #1 clr_status = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({ev_valid, fifo_count, overflow} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b count=%0d ovf=%b, want 0/0/0", ev_valid, fifo_count, overflow);
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_err_cnt: got %0d, want 0", err_cnt);
        end
        checks++;
        if ({ev_ext, ev_break, ev_code} !== 10'h000) begin
            errors++;
            $display("FAIL reset_head: got ext=%b brk=%b code=%h, want 0/0/00", ev_ext, ev_break, ev_code);
        end
    endtask

    task automatic test_single_frame();
        apply_reset();
        frame_head(8'h1C, 1'b0);
        @(negedge clk);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_s1: ev_valid=%b at S+1, want 0", ev_valid);
        end
        @(negedge clk);
        checks++;
        if ({ev_valid, ev_ext, ev_break, ev_code, fifo_count} !== {1'b1, 1'b0, 1'b0, 8'h1C, 4'd1}) begin
            errors++;
            $display("FAIL latency_s2: valid=%b ext=%b brk=%b code=%h cnt=%0d, want 1/0/0/1c/1",
                     ev_valid, ev_ext, ev_break, ev_code, fifo_count);
        end
        frame_tail();
        pop_dut();
        @(negedge clk);
        checks++;
        if ({ev_valid, fifo_count} !== 5'b0) begin
            errors++;
            $display("FAIL ack_pop: valid=%b cnt=%0d, want 0/0", ev_valid, fifo_count);
        end
    endtask

    task automatic test_prefix();
        apply_reset();
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        @(negedge clk);
        checks++;
        if ({fifo_count, ev_ext, ev_break, ev_code} !== {4'd1, 1'b1, 1'b1, 8'h75}) begin
            errors++;
            $display("FAIL prefix_ext_brk: cnt=%0d ext=%b brk=%b code=%h, want 1/1/1/75",
                     fifo_count, ev_ext, ev_break, ev_code);
        end
        checks++;
        if (nb_count !== 4'd0) begin
            errors++;
            $display("FAIL nobreak_drop: cnt=%0d, want 0", nb_count);
        end
        send_frame(8'h75, 1'b0);
        @(negedge clk);
        checks++;
        if ({nb_count, nb_ext, nb_break, nb_code} !== {4'd1, 1'b0, 1'b0, 8'h75}) begin
            errors++;
            $display("FAIL nobreak_make: cnt=%0d ext=%b brk=%b code=%h, want 1/0/0/75",
                     nb_count, nb_ext, nb_break, nb_code);
        end
        pop_dut();
        @(negedge clk);
        checks++;
        if ({fifo_count, ev_ext, ev_break, ev_code} !== {4'd1, 1'b0, 1'b0, 8'h75}) begin
            errors++;
            $display("FAIL flags_cleared: cnt=%0d ext=%b brk=%b code=%h, want 1/0/0/75",
                     fifo_count, ev_ext, ev_break, ev_code);
        end
    endtask

    task automatic test_parity_error();
        apply_reset();
        send_frame(8'h1C, 1'b1);
        @(negedge clk);
        checks++;
        if ({fifo_count, err_cnt} !== {4'd0, 8'd1}) begin
            errors++;
            $display("FAIL parity_err: cnt=%0d err=%0d, want 0/1", fifo_count, err_cnt);
        end
        send_frame(8'h29, 1'b0);
        @(negedge clk);
        checks++;
        if ({ev_valid, ev_code} !== {1'b1, 8'h29}) begin
            errors++;
            $display("FAIL after_parity: valid=%b code=%h, want 1/29", ev_valid, ev_code);
        end
        pulse_clr();
        @(negedge clk);
        checks++;
        if ({err_cnt, fifo_count} !== {8'd0, 4'd1}) begin
            errors++;
            $display("FAIL clr_status: err=%0d cnt=%0d, want 0/1", err_cnt, fifo_count);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int c = 1; c <= DEPTH + 1; c++) send_frame(8'(c), 1'b0);
        @(negedge clk);
        checks++;
        if ({fifo_count, overflow} !== {4'd8, 1'b1}) begin
            errors++;
            $display("FAIL overflow: cnt=%0d ovf=%b, want 8/1", fifo_count, overflow);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            checks++;
            if (ev_code !== 8'(i)) begin
                errors++;
                $display("FAIL drain_order: code=%h, want %h", ev_code, 8'(i));
            end
            pop_dut();
        end
        @(negedge clk);
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL drained_empty: valid=%b, want 0", ev_valid);
        end
        for (int c = 1; c <= DEPTH; c++) send_frame(8'(c), 1'b0);
        pulse_clr();
        // Ack lands on exactly the edge that pushes 0A into the full FIFO.
        frame_head(8'h0A, 1'b0);
        #1 ev_ack = 1'b1;
        @(posedge clk);
        #1 ev_ack = 1'b0;
        frame_tail();
        @(negedge clk);
        checks++;
        if ({fifo_count, overflow, ev_code} !== {4'd8, 1'b0, 8'h02}) begin
            errors++;
            $display("FAIL full_push_pop: cnt=%0d ovf=%b code=%h, want 8/0/02", fifo_count, overflow, ev_code);
        end
        repeat (DEPTH - 1) pop_dut();
        @(negedge clk);
        checks++;
        if ({fifo_count, ev_code} !== {4'd1, 8'h0A}) begin
            errors++;
            $display("FAIL full_push_tail: cnt=%0d code=%h, want 1/0a", fifo_count, ev_code);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] partial;
        partial = 8'h2D;
        apply_reset();
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(partial[i]);
        repeat (150) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({err_cnt, fifo_count} !== {8'd1, 4'd0}) begin
            errors++;
            $display("FAIL timeout: err=%0d cnt=%0d, want 1/0", err_cnt, fifo_count);
        end
        send_frame(8'h2D, 1'b0);
        @(negedge clk);
        checks++;
        if ({fifo_count, ev_code, err_cnt} !== {4'd1, 8'h2D, 8'd1}) begin
            errors++;
            $display("FAIL after_timeout: cnt=%0d code=%h err=%0d, want 1/2d/1", fifo_count, ev_code, err_cnt);
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        @(posedge clk);
        #1 ps2_data = 1'b0;
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1 ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (20) @(posedge clk);
        send_frame(8'h1C, 1'b0);
        @(negedge clk);
        checks++;
        if ({fifo_count, ev_code, err_cnt} !== {4'd1, 8'h1C, 8'd0}) begin
            errors++;
            $display("FAIL glitch: cnt=%0d code=%h err=%0d, want 1/1c/0", fifo_count, ev_code, err_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        send_frame(8'h1C, 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ev_valid, fifo_count, overflow, err_cnt, ev_ext, ev_break, ev_code} !== 24'h0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b cnt=%0d ovf=%b err=%0d code=%h, want all 0",
                     ev_valid, fifo_count, overflow, err_cnt, ev_code);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        send_frame(8'h2D, 1'b0);
        @(negedge clk);
        checks++;
        if ({fifo_count, ev_code, err_cnt} !== {4'd1, 8'h2D, 8'd0}) begin
            errors++;
            $display("FAIL after_mid_reset: cnt=%0d code=%h err=%0d, want 1/2d/0", fifo_count, ev_code, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_prefix();
        test_parity_error();
        test_overflow();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1, "time limit");
    end

endmodule
